// File: rtl/touch_menu_pkg.sv
// touch_menu_pkg
// Shared constants for the touch-panel menu controller: FSM state codes,
// menu select codes, debounce token codes and button rectangles.
// Screen coordinates are raw 12-bit touch-panel samples.
package touch_menu_pkg;

    // FSM state encodings (3 bits, codes 6 and 7 are unused)
    localparam logic [2:0] ST_MENU1      = 3'd0;
    localparam logic [2:0] ST_MENU1_WAIT = 3'd1;
    localparam logic [2:0] ST_MENU2      = 3'd2;
    localparam logic [2:0] ST_MENU2_WAIT = 3'd3;
    localparam logic [2:0] ST_MENU3      = 3'd4;
    localparam logic [2:0] ST_MENU3_WAIT = 3'd5;

    // Menu select codes driven on menu_in
    localparam logic [1:0] MENU_CODE_1 = 2'b00;
    localparam logic [1:0] MENU_CODE_2 = 2'b01;
    localparam logic [1:0] MENU_CODE_3 = 2'b10;

    // Debounce tokens: which condition the debounce counter is timing.
    // Values 1..7 name a filter button on menu 3.
    localparam logic [3:0] TOK_NONE    = 4'd0;
    localparam logic [3:0] TOK_MAIN    = 4'd8;
    localparam logic [3:0] TOK_RELEASE = 4'd9;

    // Axis-aligned button rectangle; a hit lies strictly inside the bounds
    typedef struct packed {
        logic [11:0] x0;
        logic [11:0] x1;
        logic [11:0] y0;
        logic [11:0] y1;
    } rect_t;

    // Record button on menu 1
    localparam rect_t RECORD_RECT = '{x0: 12'h700, x1: 12'h900, y0: 12'h900, y1: 12'hB00};
    // Stop button on menu 2
    localparam rect_t STOP_RECT = '{x0: 12'hC00, x1: 12'hE00, y0: 12'h900, y1: 12'hB00};
    // Record-new button on menu 3, kept clear of the filter row
    localparam rect_t RECORD_NEW_RECT = '{x0: 12'hC00, x1: 12'hE00, y0: 12'h100, y1: 12'h300};

    // Filter button row on menu 3
    localparam logic [11:0] FX0      = 12'h100;
    localparam logic [11:0] FX_PITCH = 12'h180;
    localparam logic [11:0] FX_W     = 12'h140;
    localparam logic [11:0] FY0      = 12'h7A0;
    localparam logic [11:0] FY1      = 12'hB70;

    // Rectangle of filter button k (k starts at 1)
    function automatic rect_t filter_rect(input int unsigned k);
        rect_t       r;
        logic [11:0] off;
        off  = 12'(k - 1) * FX_PITCH;
        r.x0 = FX0 + off;
        r.x1 = FX0 + off + FX_W;
        r.y0 = FY0;
        r.y1 = FY1;
        return r;
    endfunction

    // Menu code shown for a given FSM state; WAIT states still show their own menu
    function automatic logic [1:0] menu_code(input logic [2:0] st);
        logic [1:0] code;
        case (st)
            ST_MENU2, ST_MENU2_WAIT: code = MENU_CODE_2;
            ST_MENU3, ST_MENU3_WAIT: code = MENU_CODE_3;
            default:                 code = MENU_CODE_1;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/touch_menu_ctrl_region_hit.sv
// touch_region_hit
// Combinational hit test for one on-screen button: the panel is pressed
// and the sample lies strictly inside the rectangle RECT.
module touch_region_hit
    import touch_menu_pkg::*;
#(
    parameter rect_t RECT = '0
) (
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    input  logic        i_pressed,
    output logic        o_hit
);

    // Strict inequalities keep the border itself outside the button
    always_comb begin
        o_hit = i_pressed
             && (i_x > RECT.x0) && (i_x < RECT.x1)
             && (i_y > RECT.y0) && (i_y < RECT.y1);
    end

endmodule

// File: rtl/touch_menu_ctrl.sv
// touch_menu_ctrl
// Three-menu touch-panel controller. Menu 1 records, menu 2 shows a
// progress bar with a stop button, menu 3 offers filter buttons and a
// record-new button. Every press and release is debounced by one shared
// counter; each press state is followed by a WAIT state that waits for
// the finger to lift before the next menu is shown.
// Optional feature: define TOUCH_TIMEOUT_EN to return from menu 3 to
// menu 1 after TIMEOUT_CYCLES consecutive released cycles.
module touch_menu_ctrl
    import touch_menu_pkg::*;
#(
    parameter int          N_FILTERS      = 4,
    parameter int          DEBOUNCE       = 4,
    parameter int          CNT_W          = 6,
    parameter int          PROG_DONE      = 20,
    parameter logic [11:0] Z_PRESS        = 12'h800,
    parameter logic [11:0] Z_RELEASE      = 12'hF00,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] menu2_cnt,
    input  logic [11:0]      tp_x,
    input  logic [11:0]      tp_y,
    input  logic [11:0]      tp_z,
    output logic [1:0]       menu_in,
    output logic [2:0]       filter,
    output logic             menu_change
);

    // Counter holds 0..DEBOUNCE-1 prior consecutive cycles
    localparam int DEB_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);

    // Reject parameter sets the design cannot represent
    generate
        if (N_FILTERS < 1 || N_FILTERS > 7 || DEBOUNCE < 1 || CNT_W < 1
            || PROG_DONE < 0 || PROG_DONE >= (2 ** CNT_W) || TIMEOUT_CYCLES < 1
            || Z_PRESS > Z_RELEASE) begin : g_badParams
            $error("touch_menu_ctrl: parameter out of range");
        end
    endgenerate

    logic [2:0]           r_state;
    logic [2:0]           w_nextState;
    logic                 w_stateChange;
    logic [DEB_W-1:0]     r_debCnt;
    logic [3:0]           r_tok;
    logic [3:0]           w_tok;
    logic [DEB_W-1:0]     w_run;
    logic                 w_done;
    logic                 w_timeout;
    logic                 w_pressed;
    logic                 w_released;
    logic                 w_recordHit;
    logic                 w_stopHit;
    logic                 w_recordNewHit;
    logic [N_FILTERS-1:0] w_filterHit;
    logic [2:0]           w_filterSel;
    logic [1:0]           r_menuIn;
    logic                 r_menuChange;
    logic [2:0]           r_filter;

    // Z hysteresis: values between the two thresholds are neither pressed nor released
    always_comb begin
        w_pressed  = (tp_z < Z_PRESS);
        w_released = (tp_z > Z_RELEASE);
    end

    touch_region_hit #(.RECT(RECORD_RECT)) u_recordHit (
        .i_x       (tp_x),
        .i_y       (tp_y),
        .i_pressed (w_pressed),
        .o_hit     (w_recordHit)
    );

    touch_region_hit #(.RECT(STOP_RECT)) u_stopHit (
        .i_x       (tp_x),
        .i_y       (tp_y),
        .i_pressed (w_pressed),
        .o_hit     (w_stopHit)
    );

    touch_region_hit #(.RECT(RECORD_NEW_RECT)) u_recordNewHit (
        .i_x       (tp_x),
        .i_y       (tp_y),
        .i_pressed (w_pressed),
        .o_hit     (w_recordNewHit)
    );

    generate
        for (genvar k = 1; k <= N_FILTERS; k++) begin : g_filter
            touch_region_hit #(.RECT(filter_rect(k))) u_hit (
                .i_x       (tp_x),
                .i_y       (tp_y),
                .i_pressed (w_pressed),
                .o_hit     (w_filterHit[k-1])
            );
        end
    endgenerate

    // Pick the lowest-numbered filter button under the finger
    always_comb begin
        w_filterSel = 3'd0;
        for (int k = N_FILTERS; k >= 1; k--) begin
            if (w_filterHit[k-1]) begin
                w_filterSel = 3'(k);
            end
        end
    end

    // Name the condition the current state debounces; a change of token restarts the count
    always_comb begin
        w_tok = TOK_NONE;
        case (r_state)
            ST_MENU1: begin
                if (w_recordHit) w_tok = TOK_MAIN;
            end
            ST_MENU2: begin
                if (w_stopHit) w_tok = TOK_MAIN;
            end
            ST_MENU3: begin
                if (w_recordNewHit)          w_tok = TOK_MAIN;
                else if (w_filterSel != 3'd0) w_tok = {1'b0, w_filterSel};
            end
            ST_MENU1_WAIT, ST_MENU2_WAIT, ST_MENU3_WAIT: begin
                if (w_released) w_tok = TOK_RELEASE;
            end
            default: ;
        endcase
    end

    // Completed debounce: this is the DEBOUNCE-th consecutive cycle of the same token
    always_comb begin
        w_run  = ((w_tok != TOK_NONE) && (w_tok == r_tok)) ? r_debCnt : '0;
        w_done = (w_tok != TOK_NONE) && (w_run == DEB_W'(DEBOUNCE - 1));
    end

`ifdef TOUCH_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [TO_W-1:0] r_toCnt;

    // Timeout fires on the TIMEOUT_CYCLES-th consecutive released cycle in menu 3
    always_comb begin
        w_timeout = (r_state == ST_MENU3) && w_released
                 && (r_toCnt == TO_W'(TIMEOUT_CYCLES - 1));
    end

    // Count consecutive idle cycles in menu 3; anything else restarts the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_toCnt <= '0;
        end else if ((r_state == ST_MENU3) && w_released && !w_stateChange) begin
            r_toCnt <= r_toCnt + TO_W'(1);
        end else begin
            r_toCnt <= '0;
        end
    end
`else
    // Without the timeout feature menu 3 waits for a touch indefinitely
    always_comb begin
        w_timeout = 1'b0;
    end
`endif

    // Next-state logic; stop debounce takes priority over progress completion in menu 2
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_MENU1: begin
                if (w_done) w_nextState = ST_MENU1_WAIT;
            end
            ST_MENU1_WAIT: begin
                if (w_done) w_nextState = ST_MENU2;
            end
            ST_MENU2: begin
                if (w_done)                                 w_nextState = ST_MENU2_WAIT;
                else if (menu2_cnt == CNT_W'(PROG_DONE))    w_nextState = ST_MENU3;
            end
            ST_MENU2_WAIT: begin
                if (w_done) w_nextState = ST_MENU3;
            end
            ST_MENU3: begin
                if (w_done && (w_tok == TOK_MAIN)) w_nextState = ST_MENU3_WAIT;
                else if (w_timeout)                w_nextState = ST_MENU1;
            end
            ST_MENU3_WAIT: begin
                if (w_done) w_nextState = ST_MENU1;
            end
            default: w_nextState = ST_MENU1;
        endcase
        w_stateChange = (w_nextState != r_state);
    end

    // State register plus the shared debounce counter and the token it is timing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_MENU1;
            r_debCnt <= '0;
            r_tok    <= TOK_NONE;
        end else begin
            r_state <= w_nextState;
            if (w_stateChange || w_done || (w_tok == TOK_NONE)) begin
                r_debCnt <= '0;
            end else begin
                r_debCnt <= w_run + DEB_W'(1);
            end
            r_tok <= w_stateChange ? TOK_NONE : w_tok;
        end
    end

    // Menu select and change pulse are registered copies of the state, one cycle behind it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_menuIn     <= MENU_CODE_1;
            r_menuChange <= 1'b0;
        end else begin
            r_menuIn     <= menu_code(r_state);
            r_menuChange <= (menu_code(r_state) != r_menuIn);
        end
    end

    // Filter latches a debounced filter button in menu 3 and clears once menu 3 is left
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filter <= 3'd0;
        end else if (r_state != ST_MENU3) begin
            r_filter <= 3'd0;
        end else if (w_done && (w_tok != TOK_MAIN)) begin
            r_filter <= w_tok[2:0];
        end
    end

    assign menu_in     = r_menuIn;
    assign menu_change = r_menuChange;
    assign filter      = r_filter;

endmodule

// File: tb/tb_touch_menu_ctrl.sv
// tb_touch_menu_ctrl
// Directed and randomized bench for touch_menu_ctrl. A behavioural model
// tracks the menu as a number 1..3 plus a "waiting for release" flag and
// predicts menu_in, filter and menu_change every cycle.
// Compile with TOUCH_TIMEOUT_EN defined to exercise the menu 3 timeout.
module tb_touch_menu_ctrl;

    localparam int DEB  = 4;
    localparam int NF   = 4;
    localparam int PROG = 20;
    localparam int TO   = 50;

    // Touch positions used by the stimulus
    localparam int REC_X  = 'h800, REC_Y  = 'hA00;
    localparam int STOP_X = 'hD00, STOP_Y = 'hA00;
    localparam int RNEW_X = 'hD00, RNEW_Y = 'h200;
    localparam int FILT_Y = 'h900;
    localparam int ZP     = 'h100;
    localparam int ZR     = 'hF80;
    localparam int ZBAND  = 'hA00;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  menu2_cnt;
    logic [11:0] tp_x, tp_y, tp_z;
    logic [1:0]  menu_in;
    logic [2:0]  filter;
    logic        menu_change;

    int    testsRun    = 0;
    int    testsFailed = 0;
    string curTag      = "";

    // Reference model state
    int         mMenu;
    bit         mWaiting;
    int         mHoldBtn;
    int         mHoldLen;
    int         mIdle;
    logic [1:0] eMenuIn;
    logic [2:0] eFilter;
    logic       eChange;

    touch_menu_ctrl #(
        .N_FILTERS      (NF),
        .DEBOUNCE       (DEB),
        .CNT_W          (6),
        .PROG_DONE      (PROG),
        .Z_PRESS        (12'h800),
        .Z_RELEASE      (12'hF00),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .menu2_cnt   (menu2_cnt),
        .tp_x        (tp_x),
        .tp_y        (tp_y),
        .tp_z        (tp_z),
        .menu_in     (menu_in),
        .filter      (filter),
        .menu_change (menu_change)
    );

    always #5 clk = ~clk;

    function automatic int filterX(input int k);
        return 'h100 + (k - 1) * 'h180;
    endfunction

    function automatic bit inRect(input int x, input int y, input int x0, input int x1,
                                  input int y0, input int y1);
        return (x > x0) && (x < x1) && (y > y0) && (y < y1);
    endfunction

    // Button under (x,y) on a given menu: 100 = the menu's main button, k = filter k
    function automatic int buttonAt(input int menu, input int x, input int y);
        if (menu == 1) return inRect(x, y, 'h700, 'h900, 'h900, 'hB00) ? 100 : 0;
        if (menu == 2) return inRect(x, y, 'hC00, 'hE00, 'h900, 'hB00) ? 100 : 0;
        if (inRect(x, y, 'hC00, 'hE00, 'h100, 'h300)) return 100;
        for (int k = 1; k <= NF; k++) begin
            if (inRect(x, y, filterX(k), filterX(k) + 'h140, 'h7A0, 'hB70)) return k;
        end
        return 0;
    endfunction

    task automatic modelReset();
        mMenu    = 1;
        mWaiting = 1'b0;
        mHoldBtn = 0;
        mHoldLen = 0;
        mIdle    = 0;
        eMenuIn  = 2'd0;
        eFilter  = 3'd0;
        eChange  = 1'b0;
    endtask

    // One clock of the model, using the inputs present at the edge
    task automatic modelStep();
        int  cond;
        bit  pressed, released, done, timedOut;
        int  oldMenu;
        bit  oldWaiting;
        pressed  = (int'(tp_z) < 'h800);
        released = (int'(tp_z) > 'hF00);
        if (mWaiting) cond = released ? 200 : 0;
        else          cond = pressed ? buttonAt(mMenu, int'(tp_x), int'(tp_y)) : 0;
        if (cond == 0)             mHoldLen = 0;
        else if (cond == mHoldBtn) mHoldLen++;
        else                       mHoldLen = 1;
        mHoldBtn = cond;
        done = (cond != 0) && (mHoldLen == DEB);
        if (done) mHoldLen = 0;

        eChange = (2'(mMenu - 1) != eMenuIn);
        eMenuIn = 2'(mMenu - 1);
        if (mMenu != 3 || mWaiting) eFilter = 3'd0;
        else if (done && cond >= 1 && cond <= NF) eFilter = 3'(cond);

        timedOut = 1'b0;
`ifdef TOUCH_TIMEOUT_EN
        if (mMenu == 3 && !mWaiting && released) begin
            mIdle++;
            if (mIdle == TO) timedOut = 1'b1;
        end else begin
            mIdle = 0;
        end
`endif

        oldMenu    = mMenu;
        oldWaiting = mWaiting;
        if (done && mWaiting) begin
            mMenu    = (mMenu % 3) + 1;
            mWaiting = 1'b0;
        end else if (done && cond == 100) begin
            mWaiting = 1'b1;
        end else if (mMenu == 2 && !mWaiting && int'(menu2_cnt) == PROG) begin
            mMenu = 3;
        end else if (timedOut) begin
            mMenu = 1;
        end
        if (mMenu != oldMenu || mWaiting != oldWaiting) begin
            mHoldLen = 0;
            mHoldBtn = 0;
            mIdle    = 0;
        end
    endtask

    task automatic checkOutput(input string tag);
        testsRun++;
        assert (menu_in === eMenuIn) else begin
            testsFailed++;
            $error("[TB] FAIL %s menu_in: observed %0d expected %0d", tag, menu_in, eMenuIn);
        end
        testsRun++;
        assert (filter === eFilter) else begin
            testsFailed++;
            $error("[TB] FAIL %s filter: observed %0d expected %0d", tag, filter, eFilter);
        end
        testsRun++;
        assert (menu_change === eChange) else begin
            testsFailed++;
            $error("[TB] FAIL %s menu_change: observed %0d expected %0d", tag, menu_change, eChange);
        end
    endtask

    task automatic checkConst(input string tag, input int observed, input int expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock, update the model, then check 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        if (reset) modelReset();
        else       modelStep();
        #1;
        checkOutput(curTag);
    endtask

    task automatic applyStimulus(input string tag, input int x, input int y, input int z,
                                 input int cnt, input int n);
        curTag    = tag;
        tp_x      = 12'(x);
        tp_y      = 12'(y);
        tp_z      = 12'(z);
        menu2_cnt = 6'(cnt);
        repeat (n) tick();
    endtask

    // Assert reset between edges, check the asynchronous clear, hold it one edge
    task automatic doAsyncReset(input string tag);
        reset = 1'b1;
        #1;
        modelReset();
        checkConst({tag, " async menu_in"}, int'(menu_in), 0);
        checkConst({tag, " async filter"}, int'(filter), 0);
        checkConst({tag, " async menu_change"}, int'(menu_change), 0);
        curTag = {tag, " hold"};
        tick();
        reset = 1'b0;
    endtask

    task automatic gotoMenu3();
        applyStimulus("to m3 record", REC_X, REC_Y, ZP, 0, DEB);
        applyStimulus("to m3 release", 0, 0, ZR, 0, DEB);
        applyStimulus("to m3 progress", 0, 0, ZR, PROG, 1);
        applyStimulus("to m3 settle", 0, 0, ZR, 0, 1);
    endtask

    initial begin
        int x, y, z, cnt, k;
        modelReset();
        reset     = 1'b1;
        tp_x      = 12'd0;
        tp_y      = 12'd0;
        tp_z      = 12'hFFF;
        menu2_cnt = 6'd0;

        applyStimulus("reset", 0, 0, 'hFFF, 0, 2);
        checkConst("reset menu_in", int'(menu_in), 0);
        checkConst("reset filter", int'(filter), 0);
        checkConst("reset menu_change", int'(menu_change), 0);
        reset = 1'b0;

        applyStimulus("short press", REC_X, REC_Y, ZP, 0, DEB - 1);
        applyStimulus("short release", 0, 0, ZR, 0, 6);
        checkConst("short press menu_in", int'(menu_in), 0);

        applyStimulus("record", REC_X, REC_Y, ZP, 0, DEB);
        applyStimulus("band", REC_X, REC_Y, ZBAND, 0, 10);
        checkConst("band menu_in", int'(menu_in), 0);
        applyStimulus("release m1", 0, 0, ZR, 0, DEB);
        checkConst("release lag menu_in", int'(menu_in), 0);
        applyStimulus("enter m2", 0, 0, ZR, 0, 1);
        checkConst("enter m2 menu_in", int'(menu_in), 1);
        checkConst("enter m2 pulse", int'(menu_change), 1);
        applyStimulus("m2 steady", 0, 0, ZR, 0, 1);
        checkConst("m2 pulse end", int'(menu_change), 0);

        applyStimulus("progress done", 0, 0, ZR, PROG, 1);
        checkConst("progress lag menu_in", int'(menu_in), 1);
        applyStimulus("progress settle", 0, 0, ZR, 0, 1);
        checkConst("progress menu_in", int'(menu_in), 2);

        applyStimulus("filter3", filterX(3) + 'hA0, FILT_Y, ZP, 0, DEB);
        checkConst("filter3 latched", int'(filter), 3);
        applyStimulus("filter1 short", filterX(1) + 'hA0, FILT_Y, ZP, 0, 2);
        checkConst("filter1 short keeps 3", int'(filter), 3);
        applyStimulus("record_new", RNEW_X, RNEW_Y, ZP, 0, DEB);
        checkConst("record_new filter held", int'(filter), 3);
        applyStimulus("m3 wait release", 0, 0, ZR, 0, 1);
        checkConst("filter cleared", int'(filter), 0);
        applyStimulus("m3 wait release", 0, 0, ZR, 0, DEB);
        checkConst("back to m1 menu_in", int'(menu_in), 0);
        checkConst("back to m1 pulse", int'(menu_change), 1);

        applyStimulus("to m2 record", REC_X, REC_Y, ZP, 0, DEB);
        applyStimulus("to m2 release", 0, 0, ZR, 0, DEB);
        applyStimulus("stop", STOP_X, STOP_Y, ZP, 0, DEB - 1);
        applyStimulus("stop with progress", STOP_X, STOP_Y, ZP, PROG, 1);
        applyStimulus("stop held", STOP_X, STOP_Y, ZP, 0, 2);
        checkConst("stop wins menu_in", int'(menu_in), 1);
        applyStimulus("stop release", 0, 0, ZR, 0, DEB + 1);
        checkConst("after stop menu_in", int'(menu_in), 2);

        applyStimulus("filter2 partial", filterX(2) + 'h10, FILT_Y, ZP, 0, DEB - 1);
        doAsyncReset("mid filter reset");
        applyStimulus("record partial", REC_X, REC_Y, ZP, 0, 2);
        doAsyncReset("mid record reset");
        applyStimulus("record after reset", REC_X, REC_Y, ZP, 0, 2);
        applyStimulus("release after reset", 0, 0, ZR, 0, 6);
        checkConst("aborted debounce menu_in", int'(menu_in), 0);

        gotoMenu3();
        applyStimulus("timeout filter2", filterX(2) + 'hA0, FILT_Y, ZP, 0, DEB);
`ifdef TOUCH_TIMEOUT_EN
        applyStimulus("timeout partial", 0, 0, ZR, 0, 25);
        doAsyncReset("timeout reset");
        checkConst("timeout reset menu_in", int'(menu_in), 0);
        gotoMenu3();
        applyStimulus("timeout filter2 again", filterX(2) + 'hA0, FILT_Y, ZP, 0, DEB);
        applyStimulus("timeout idle", 0, 0, ZR, 0, TO - 1);
        checkConst("timeout edge menu_in", int'(menu_in), 2);
        applyStimulus("timeout last", 0, 0, ZR, 0, 1);
        applyStimulus("timeout settle", 0, 0, ZR, 0, 1);
        checkConst("timeout menu_in", int'(menu_in), 0);
        checkConst("timeout filter", int'(filter), 0);
        checkConst("timeout pulse", int'(menu_change), 1);
`else
        applyStimulus("no timeout idle", 0, 0, ZR, 0, TO + 10);
        checkConst("no timeout menu_in", int'(menu_in), 2);
        checkConst("no timeout filter", int'(filter), 2);
`endif

        // Random segments: mixed positions, z levels around both thresholds, progress counts
        for (int seg = 0; seg < 400; seg++) begin
            k = int'($urandom_range(1, NF));
            case ($urandom_range(0, 9))
                0: begin x = REC_X;  y = REC_Y;  end
                1: begin x = STOP_X; y = STOP_Y; end
                2: begin x = RNEW_X; y = RNEW_Y; end
                3, 4: begin x = filterX(k) + 'hA0; y = FILT_Y; end
                5: begin x = filterX(k) + int'($urandom_range(0, 1)); y = FILT_Y; end
                6: begin x = 'h700 + int'($urandom_range(0, 1)); y = REC_Y; end
                7: begin x = int'($urandom_range(0, 4095)); y = int'($urandom_range(0, 4095)); end
                default: begin x = 0; y = 0; end
            endcase
            case ($urandom_range(0, 9))
                0, 1: z = ZP;
                2, 3: z = ZR;
                4: z = ZBAND;
                5: z = 'h800;
                6: z = 'h7FF;
                7: z = 'hF00;
                8: z = 'hF01;
                default: z = int'($urandom_range(0, 4095));
            endcase
            cnt = ($urandom_range(0, 7) == 0) ? PROG : int'($urandom_range(0, 63));
            applyStimulus("random", x, y, z, cnt, int'($urandom_range(1, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
